regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port (RegWEn/rsW/dataW) between two writers.
  - Primary: the in-order pipeline writeback stage.
  - Secondary: a long-latency unit, e.g. a divider or a load return.
- Primary writes have priority. Secondary writes are buffered in a small FIFO and drained into idle write slots.
- Exports a pending-destination mask so the issue logic can detect hazards against buffered writes.
- Sits between writeback and the register file.

Parameters:
- DEPTH, 2, secondary FIFO entries; power of two, 2..8.
- MAX_WAIT, 8, cycles the FIFO head may wait before forced grant (used only with REGWR_AGING_EN).

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- pri_valid_i  in  1  primary write request this cycle
- pri_rd_i  in  5  primary destination register
- pri_data_i  in  32  primary write data
- pri_stall_o  out  1  primary request not taken this cycle; hold request stable
- sec_valid_i  in  1  secondary write offer
- sec_ready_o  out  1  FIFO can accept an entry
- sec_rd_i  in  5  secondary destination register
- sec_data_i  in  32  secondary write data
- pend_mask_o  out  32  bit r=1 while a live FIFO entry targets xr
- RegWEn_o  out  1  register-file write enable (registered)
- rsW_o  out  5  register-file write index (registered)
- dataW_o  out  32  register-file write data (registered)

Behaviour:
- Reset (async, rst_n_i=0):
  - RegWEn_o=0, rsW_o=0, dataW_o=0.
  - FIFO empty, all entry valid bits 0, pend_mask_o=0.
  - sec_ready_o=0, pri_stall_o=0, age counter 0.
  - After deassertion, sec_ready_o=1 from the first clock edge.
- Reset asserted mid-operation discards all buffered entries. No write is issued for them.
- Primary accept:
  - A request is taken when pri_valid_i=1 and pri_stall_o=0.
  - Take at edge N drives RegWEn_o=1, rsW_o=pri_rd_i, dataW_o=pri_data_i during cycle N+1.
- Secondary accept:
  - Enqueue on sec_valid_i & sec_ready_o at edge N.
  - sec_ready_o = !full. There is no same-cycle enqueue-while-full, even if a pop occurs.
- Head grant:
  - The FIFO head (live, valid=1) is granted in any cycle with no primary take.
  - Grant at edge M drives the write port in cycle M+1.
  - Earliest secondary write is the cycle after enqueue +1, i.e. enqueue edge N gives a write in cycle N+2.
- Idle: when neither source is granted, RegWEn_o=0 next cycle. rsW_o and dataW_o hold their last values.
- x0 writes:
  - Primary rd=0 is taken but produces RegWEn_o=0 and occupies no slot; the FIFO head may be granted that cycle.
  - Secondary rd=0 is accepted and dropped, with no FIFO entry.
- Squash (ordering rule):
  - A primary take with rd=X (X≠0) clears the valid bit of every entry already in the FIFO with rd=X. Primary is younger by contract.
  - An entry enqueued on that same edge is not squashed.
  - An invalid entry at the head is popped in one cycle without using the write port, regardless of primary activity.
- pend_mask_o:
  - OR of one-hot(rd) over valid entries.
  - Updated on the edge after enqueue, squash, or pop (registered).
- FIFO pointers are log2(DEPTH)+1 bits, wrapping naturally.
  - full: pointers equal except the MSB.
  - empty: pointers fully equal.
- pri_stall_o is 0 at all times without aging.

Optional Feature:
- REGWR_AGING_EN defined:
  - An age counter increments each cycle the FIFO head is live and not granted. It saturates at MAX_WAIT.
  - It clears on head grant, on head pop, or when the FIFO is empty.
  - When the counter equals MAX_WAIT:
    - pri_stall_o=1 (combinational, that cycle).
    - The head is granted instead of the primary.
    - The primary holds its request and is taken on the following cycle.
    - No squash occurs from a stalled primary.
- REGWR_AGING_EN undefined: no counter logic, pri_stall_o tied 0, and the secondary may starve indefinitely.

Test Plan:
- Reset then primary only:
  - Stimulus: pri rd=5, data=0xDEADBEEF at edge 1.
  - Required: cycle 2 RegWEn_o=1, rsW_o=5, dataW_o=0xDEADBEEF; cycle 3 RegWEn_o=0.
- Secondary while primary idle:
  - Stimulus: enqueue rd=7, data=0x11 at edge 1.
  - Required: pend_mask_o=0x80 in cycle 2; write rd=7 in cycle 3; pend_mask_o=0 in cycle 4.
- Full backpressure (DEPTH=2):
  - Stimulus: primary busy every cycle; enqueue rd=3, then rd=4.
  - Required: sec_ready_o=0, a third offer is held, pend_mask_o=0x18.
  - Release primary: writes rd=3 then rd=4 in order, and sec_ready_o returns to 1.
- Squash:
  - Stimulus: FIFO holds rd=9, data=0xAA; primary takes rd=9, data=0xBB.
  - Required: only 0xBB is written to x9; pend_mask_o bit 9 clears the next cycle; the dead head pops with no write.
- x0 and mid-operation reset:
  - Stimulus: primary rd=0 with FIFO rd=2.
  - Required: the rd=2 write occurs in the following cycle.
  - Then: assert rst_n_i with 2 entries buffered. Required: all outputs 0 immediately and no later write.
- Aging (macro defined, MAX_WAIT=4):
  - Stimulus: primary continuous, one FIFO entry.
  - Required: pri_stall_o=1 in the 5th cycle after the head becomes live, the head is written, and the stalled primary is written the next cycle.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
// rtl/regfile_wport_arbiter_if.sv - write-port arbiter signal bundle (writers, pending mask, register-file port)
interface regfile_wport_arbiter_if;
    logic        pri_valid_i;
    logic [4:0]  pri_rd_i;
    logic [31:0] pri_data_i;
    logic        pri_stall_o;
    logic        sec_valid_i;
    logic        sec_ready_o;
    logic [4:0]  sec_rd_i;
    logic [31:0] sec_data_i;
    logic [31:0] pend_mask_o;
    logic        RegWEn_o;
    logic [4:0]  rsW_o;
    logic [31:0] dataW_o;

    modport slave (
        input  pri_valid_i, pri_rd_i, pri_data_i,
        input  sec_valid_i, sec_rd_i, sec_data_i,
        output pri_stall_o, sec_ready_o, pend_mask_o,
        output RegWEn_o, rsW_o, dataW_o
    );

    modport master (
        output pri_valid_i, pri_rd_i, pri_data_i,
        output sec_valid_i, sec_rd_i, sec_data_i,
        input  pri_stall_o, sec_ready_o, pend_mask_o,
        input  RegWEn_o, rsW_o, dataW_o
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - register-file write-port arbiter, primary priority, buffered secondary
// Optional head aging / forced grant enabled by defining REGWR_AGING_EN.
module regfile_wport_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    regfile_wport_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_param_check
        $error("regfile_wport_arbiter: unsupported DEPTH or MAX_WAIT");
    end

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic             ready_en_q;

    logic [AW-1:0] head, tail;
    logic          full, empty, head_live, head_dead;
    logic          force_head, pri_take, pri_wr, grant, pop, push;
    logic [31:0]   pend;

    assign head  = rd_ptr_q[AW-1:0];
    assign tail  = wr_ptr_q[AW-1:0];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head_live = !empty && vld_q[head];
    assign head_dead = !empty && !vld_q[head];

`ifdef REGWR_AGING_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] age_q;

    assign force_head = head_live && (age_q == CW'(MAX_WAIT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            age_q <= '0;
        end else if (empty || pop) begin
            age_q <= '0;
        end else if (head_live && age_q != CW'(MAX_WAIT)) begin
            age_q <= age_q + CW'(1);
        end
    end
`else
    assign force_head = 1'b0;
`endif

    assign bus.pri_stall_o = force_head;
    assign bus.sec_ready_o = ready_en_q && !full;

    // x0 primary writes are taken but leave the port free for the FIFO head
    assign pri_take = bus.pri_valid_i && !force_head;
    assign pri_wr   = pri_take && (bus.pri_rd_i != 5'd0);
    assign grant    = head_live && (force_head || !pri_wr);
    assign pop      = grant || head_dead;
    assign push     = bus.sec_valid_i && bus.sec_ready_o && (bus.sec_rd_i != 5'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            vld_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            // Squash runs first so an entry enqueued on this same edge survives
            for (int i = 0; i < DEPTH; i++) begin
                if (pri_wr && rd_q[i] == bus.pri_rd_i) begin
                    vld_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                vld_q[head] <= 1'b0;
                rd_ptr_q    <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                vld_q[tail] <= 1'b1;
                wr_ptr_q    <= wr_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_q[tail]   <= bus.sec_rd_i;
            data_q[tail] <= bus.sec_data_i;
        end
    end

    // Unoccupied slots always have vld=0, so no occupancy qualification is needed
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend[rd_q[i]] = 1'b1;
            end
        end
    end
    assign bus.pend_mask_o = pend;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.RegWEn_o <= 1'b0;
            bus.rsW_o    <= '0;
            bus.dataW_o  <= '0;
        end else if (pri_wr && !force_head) begin
            bus.RegWEn_o <= 1'b1;
            bus.rsW_o    <= bus.pri_rd_i;
            bus.dataW_o  <= bus.pri_data_i;
        end else if (grant) begin
            bus.RegWEn_o <= 1'b1;
            bus.rsW_o    <= rd_q[head];
            bus.dataW_o  <= data_q[head];
        end else begin
            bus.RegWEn_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - directed self-checking bench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    regfile_wport_arbiter_if bus ();

    regfile_wport_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, ".en"}, {31'd0, bus.RegWEn_o}, {31'd0, en});
        chk({tag, ".rd"}, {27'd0, bus.rsW_o}, {27'd0, rd});
        chk({tag, ".data"}, bus.dataW_o, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.pri_valid_i = 1'b0; bus.pri_rd_i = '0; bus.pri_data_i = '0;
        bus.sec_valid_i = 1'b0; bus.sec_rd_i = '0; bus.sec_data_i = '0;
        #2;
        chk_wr("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.pend", bus.pend_mask_o, 32'h0);
        chk("reset.ready", {31'd0, bus.sec_ready_o}, 32'd0);
        chk("reset.stall", {31'd0, bus.pri_stall_o}, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("post_reset.ready", {31'd0, bus.sec_ready_o}, 32'd1);

        // Primary only
        bus.pri_valid_i = 1'b1; bus.pri_rd_i = 5'd5; bus.pri_data_i = 32'hDEADBEEF;
        tick();
        chk_wr("pri", 1'b1, 5'd5, 32'hDEADBEEF);
        bus.pri_valid_i = 1'b0;
        tick();
        chk_wr("pri_idle", 1'b0, 5'd5, 32'hDEADBEEF);

        // Secondary while primary idle
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd7; bus.sec_data_i = 32'h11;
        tick();
        bus.sec_valid_i = 1'b0;
        chk("sec.pend", bus.pend_mask_o, 32'h80);
        chk("sec.no_write_yet", {31'd0, bus.RegWEn_o}, 32'd0);
        tick();
        chk_wr("sec.write", 1'b1, 5'd7, 32'h11);
        tick();
        chk("sec.pend_clear", bus.pend_mask_o, 32'h0);
        chk("sec.idle", {31'd0, bus.RegWEn_o}, 32'd0);

        // Full backpressure with primary busy
        bus.pri_valid_i = 1'b1; bus.pri_rd_i = 5'd1; bus.pri_data_i = 32'h100;
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd3; bus.sec_data_i = 32'h33;
        tick();
        bus.sec_rd_i = 5'd4; bus.sec_data_i = 32'h44;
        tick();
        chk("full.ready", {31'd0, bus.sec_ready_o}, 32'd0);
        chk("full.pend", bus.pend_mask_o, 32'h18);
        chk_wr("full.pri", 1'b1, 5'd1, 32'h100);
        bus.sec_rd_i = 5'd6; bus.sec_data_i = 32'h66;
        tick();
        chk("full.held_ready", {31'd0, bus.sec_ready_o}, 32'd0);
        chk("full.held_pend", bus.pend_mask_o, 32'h18);
        bus.pri_valid_i = 1'b0;
        tick();
        chk_wr("drain0", 1'b1, 5'd3, 32'h33);
        chk("drain0.ready", {31'd0, bus.sec_ready_o}, 32'd1);
        chk("drain0.pend", bus.pend_mask_o, 32'h10);
        tick();
        bus.sec_valid_i = 1'b0;
        chk_wr("drain1", 1'b1, 5'd4, 32'h44);
        chk("drain1.pend", bus.pend_mask_o, 32'h40);
        tick();
        chk_wr("drain2", 1'b1, 5'd6, 32'h66);
        chk("drain2.pend", bus.pend_mask_o, 32'h0);
        tick();
        chk("drain.idle", {31'd0, bus.RegWEn_o}, 32'd0);

        // Squash of an older buffered write to the same register
        bus.pri_valid_i = 1'b1; bus.pri_rd_i = 5'd10; bus.pri_data_i = 32'h1010;
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd9; bus.sec_data_i = 32'hAA;
        tick();
        bus.sec_valid_i = 1'b0;
        chk("squash.pend_before", bus.pend_mask_o, 32'h200);
        bus.pri_rd_i = 5'd9; bus.pri_data_i = 32'hBB;
        tick();
        chk_wr("squash.pri", 1'b1, 5'd9, 32'hBB);
        chk("squash.pend_after", bus.pend_mask_o, 32'h0);
        bus.pri_valid_i = 1'b0;
        tick();
        chk_wr("squash.dead_pop", 1'b0, 5'd9, 32'hBB);
        tick();
        chk_wr("squash.no_stale", 1'b0, 5'd9, 32'hBB);

        // Same-edge enqueue is not squashed
        bus.pri_valid_i = 1'b1; bus.pri_rd_i = 5'd12; bus.pri_data_i = 32'hC1;
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd12; bus.sec_data_i = 32'hC2;
        tick();
        bus.pri_valid_i = 1'b0; bus.sec_valid_i = 1'b0;
        chk_wr("same_edge.pri", 1'b1, 5'd12, 32'hC1);
        chk("same_edge.pend", bus.pend_mask_o, 32'h1000);
        tick();
        chk_wr("same_edge.sec", 1'b1, 5'd12, 32'hC2);

        // Primary x0 frees the slot for the FIFO head
        bus.pri_valid_i = 1'b1; bus.pri_rd_i = 5'd11; bus.pri_data_i = 32'hB1;
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd2; bus.sec_data_i = 32'h22;
        tick();
        bus.sec_valid_i = 1'b0;
        chk("x0.pend", bus.pend_mask_o, 32'h4);
        bus.pri_rd_i = 5'd0; bus.pri_data_i = 32'hFFFF;
        tick();
        chk_wr("x0.head_write", 1'b1, 5'd2, 32'h22);
        bus.pri_valid_i = 1'b0;
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd0; bus.sec_data_i = 32'h77;
        tick();
        bus.sec_valid_i = 1'b0;
        chk("x0.sec_drop_pend", bus.pend_mask_o, 32'h0);
        chk("x0.sec_drop_idle", {31'd0, bus.RegWEn_o}, 32'd0);
        tick();
        chk("x0.sec_no_write", {31'd0, bus.RegWEn_o}, 32'd0);
        chk("nostall", {31'd0, bus.pri_stall_o}, 32'd0);

        // Mid-operation reset with two buffered entries
        bus.pri_valid_i = 1'b1; bus.pri_rd_i = 5'd13; bus.pri_data_i = 32'hD13;
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd14; bus.sec_data_i = 32'hE14;
        tick();
        bus.sec_rd_i = 5'd15; bus.sec_data_i = 32'hF15;
        tick();
        chk("midrst.pend_before", bus.pend_mask_o, 32'hC000);
        bus.pri_valid_i = 1'b0; bus.sec_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_wr("midrst", 1'b0, 5'd0, 32'h0);
        chk("midrst.pend", bus.pend_mask_o, 32'h0);
        chk("midrst.ready", {31'd0, bus.sec_ready_o}, 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midrst.no_write%0d", i), {31'd0, bus.RegWEn_o}, 32'd0);
        end

`ifdef REGWR_AGING_EN
        // Aging: continuous primary, one buffered entry, MAX_WAIT=4
        bus.pri_valid_i = 1'b1; bus.pri_rd_i = 5'd20; bus.pri_data_i = 32'h5000;
        bus.sec_valid_i = 1'b1; bus.sec_rd_i = 5'd21; bus.sec_data_i = 32'h5151;
        tick();
        bus.sec_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("age.no_stall%0d", i), {31'd0, bus.pri_stall_o}, 32'd0);
            if (i < 3) tick();
        end
        tick();
        chk("age.stall", {31'd0, bus.pri_stall_o}, 32'd1);
        tick();
        chk_wr("age.head", 1'b1, 5'd21, 32'h5151);
        chk("age.stall_clear", {31'd0, bus.pri_stall_o}, 32'd0);
        tick();
        chk_wr("age.held_pri", 1'b1, 5'd20, 32'h5000);
        bus.pri_valid_i = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
